// File: rtl/alu_issue_if.sv
// Producer-side alu issue bus: upstream instruction handshake, flush, and the
// registered operand/control handshake toward execute.
interface alu_issue_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  srca;
  logic [XLEN-1:0]  srcb;
  logic [5:0]       aluCtrl;
  logic [4:0]       rd;
  logic             reg_write;
  logic             is_branch;
  logic             illegal;
  logic [CNT_W-1:0] issue_cnt;

  modport master (
    input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, out_valid, srca, srcb, aluCtrl, rd, reg_write,
           is_branch, illegal, issue_cnt
  );

  modport slave (
    output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, out_valid, srca, srcb, aluCtrl, rd, reg_write,
           is_branch, illegal, issue_cnt
  );
endinterface

// File: rtl/alu_issue.sv
// Single-entry ID/EX stage: decodes an RV32I instruction into an alu opcode,
// selects operands and holds them behind a valid/ready handshake.
module alu_issue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input logic         clk,
  input logic         rst,
  alu_issue_if.master bus
);
  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SUB  = 6'd1;
  localparam logic [5:0] ALU_XOR  = 6'd2;
  localparam logic [5:0] ALU_SLL  = 6'd3;
  localparam logic [5:0] ALU_SLT  = 6'd4;
  localparam logic [5:0] ALU_SRL  = 6'd5;
  localparam logic [5:0] ALU_SRA  = 6'd6;
  localparam logic [5:0] ALU_AND  = 6'd7;
  localparam logic [5:0] ALU_OR   = 6'd8;
  localparam logic [5:0] ALU_BEQ  = 6'd9;
  localparam logic [5:0] ALU_BNE  = 6'd10;
  localparam logic [5:0] ALU_BLT  = 6'd11;
  localparam logic [5:0] ALU_BGE  = 6'd12;
  localparam logic [5:0] ALU_SLTU = 6'd13;
  localparam logic [5:0] ALU_BLTU = 6'd14;
  localparam logic [5:0] ALU_BGEU = 6'd15;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rd_idx;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, shamt;

  logic [5:0]      d_ctrl;
  logic [XLEN-1:0] d_srca, d_srcb;
  logic            d_rw, d_br, d_ill;

  logic load, xfer;

  assign opcode = bus.instr[6:0];
  assign f3     = bus.instr[14:12];
  assign f7     = bus.instr[31:25];
  assign rd_idx = bus.instr[11:7];
  assign imm_i  = XLEN'($signed(bus.instr[31:20]));
  assign imm_s  = XLEN'($signed({bus.instr[31:25], bus.instr[11:7]}));
  assign imm_u  = XLEN'($signed({bus.instr[31:12], 12'b0}));
  assign shamt  = XLEN'(bus.instr[24:20]);

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready;
  assign xfer         = bus.out_valid && bus.out_ready;

  // Shared funct3 map for register and immediate ALU forms
  function automatic logic [5:0] f3_ctrl(input logic [2:0] f);
    case (f)
      3'b000:  f3_ctrl = ALU_ADD;
      3'b001:  f3_ctrl = ALU_SLL;
      3'b010:  f3_ctrl = ALU_SLT;
      3'b011:  f3_ctrl = ALU_SLTU;
      3'b100:  f3_ctrl = ALU_XOR;
      3'b101:  f3_ctrl = ALU_SRL;
      3'b110:  f3_ctrl = ALU_OR;
      default: f3_ctrl = ALU_AND;
    endcase
  endfunction

  always_comb begin
    d_ctrl = ALU_ADD;
    d_srca = '0;
    d_srcb = '0;
    d_rw   = 1'b0;
    d_br   = 1'b0;
    d_ill  = 1'b0;
    case (opcode)
      OPC_OP: begin
        d_srca = bus.rs1_data;
        d_srcb = bus.rs2_data;
        d_rw   = 1'b1;
        d_ctrl = f3_ctrl(f3);
        if (f7 == F7_ALT && f3 == 3'b000)      d_ctrl = ALU_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101) d_ctrl = ALU_SRA;
        else if (f7 != F7_ZERO)                d_ill  = 1'b1;
      end
      OPC_OPIMM: begin
        d_srca = bus.rs1_data;
        d_srcb = imm_i;
        d_rw   = 1'b1;
        d_ctrl = f3_ctrl(f3);
        // Shifts take a 5-bit shamt; funct7 selects srai or is illegal
        if (f3 == 3'b001) begin
          d_srcb = shamt;
          if (f7 != F7_ZERO) d_ill = 1'b1;
        end else if (f3 == 3'b101) begin
          d_srcb = shamt;
          if (f7 == F7_ALT)       d_ctrl = ALU_SRA;
          else if (f7 != F7_ZERO) d_ill  = 1'b1;
        end
      end
      OPC_LOAD: begin
        d_srca = bus.rs1_data;
        d_srcb = imm_i;
        d_rw   = 1'b1;
      end
      OPC_STORE: begin
        d_srca = bus.rs1_data;
        d_srcb = imm_s;
      end
      OPC_BRANCH: begin
        d_srca = bus.rs1_data;
        d_srcb = bus.rs2_data;
        d_br   = 1'b1;
        case (f3)
          3'b000:  d_ctrl = ALU_BEQ;
          3'b001:  d_ctrl = ALU_BNE;
          3'b100:  d_ctrl = ALU_BLT;
          3'b101:  d_ctrl = ALU_BGE;
          3'b110:  d_ctrl = ALU_BLTU;
          3'b111:  d_ctrl = ALU_BGEU;
          default: d_ill  = 1'b1;
        endcase
      end
      OPC_LUI: begin
        d_srcb = imm_u;
        d_rw   = 1'b1;
      end
      OPC_AUIPC: begin
        d_srca = bus.pc;
        d_srcb = imm_u;
        d_rw   = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        d_srca = bus.pc;
        d_srcb = XLEN'(4);
        d_rw   = 1'b1;
        if (opcode == OPC_JALR && f3 != 3'b000) d_ill = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_ctrl = ALU_ADD;
      d_srca = '0;
      d_srcb = '0;
      d_rw   = 1'b0;
      d_br   = 1'b0;
    end
    if (rd_idx == 5'd0) d_rw = 1'b0;
  end

  // Output register; flush wins over a same-cycle load but a transfer still counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.srca      <= '0;
      bus.srcb      <= '0;
      bus.aluCtrl   <= ALU_ADD;
      bus.rd        <= '0;
      bus.reg_write <= 1'b0;
      bus.is_branch <= 1'b0;
      bus.illegal   <= 1'b0;
      bus.issue_cnt <= '0;
    end else begin
      if (xfer) bus.issue_cnt <= bus.issue_cnt + CNT_W'(1);
      if (bus.flush) begin
        bus.out_valid <= 1'b0;
      end else if (load) begin
        bus.out_valid <= 1'b1;
        bus.srca      <= d_srca;
        bus.srcb      <= d_srcb;
        bus.aluCtrl   <= d_ctrl;
        bus.rd        <= rd_idx;
        bus.reg_write <= d_rw;
        bus.is_branch <= d_br;
        bus.illegal   <= d_ill;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// Directed-vector bench for alu_issue: decode cases, handshake, flush and reset.
module tb_alu_issue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_cnt = 32'd0;

  alu_issue_if #(.XLEN(32), .CNT_W(32)) bus ();
  alu_issue #(.XLEN(32), .CNT_W(32)) u_dut (.clk(clk), .rst(rst), .bus(bus.master));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction with out_ready low so it is held for inspection
  task automatic load_one(input logic [31:0] i, input logic [31:0] p,
                          input logic [31:0] r1, input logic [31:0] r2);
    bus.in_valid = 1'b1; bus.instr = i; bus.pc = p;
    bus.rs1_data = r1; bus.rs2_data = r2; bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    bus.instr = 32'h0; bus.pc = 32'h0; bus.rs1_data = 32'h0; bus.rs2_data = 32'h0;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.aluCtrl !== 6'd0) begin errors++; $display("FAIL rst_aluCtrl got=%0d exp=0", bus.aluCtrl); end
    checks++; if (bus.issue_cnt !== 32'd0) begin errors++; $display("FAIL rst_issue_cnt got=%0d exp=0", bus.issue_cnt); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    #2 rst = 1'b0;
    step();
  endtask

  task automatic test_add();
    load_one(32'h002081B3, 32'h0, 32'd21, 32'd10); // add x3,x1,x2
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.aluCtrl !== 6'd0) begin errors++; $display("FAIL add_ctrl got=%0d exp=0", bus.aluCtrl); end
    checks++; if (bus.srca !== 32'd21 || bus.srcb !== 32'd10) begin errors++; $display("FAIL add_src got=%0d,%0d exp=21,10", bus.srca, bus.srcb); end
    checks++; if (bus.rd !== 5'd3 || bus.reg_write !== 1'b1) begin errors++; $display("FAIL add_wb got=%0d,%b exp=3,1", bus.rd, bus.reg_write); end
    drain();
    checks++; if (bus.issue_cnt !== exp_cnt) begin errors++; $display("FAIL add_cnt got=%0d exp=%0d", bus.issue_cnt, exp_cnt); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_drop got=%b exp=0", bus.out_valid); end
    load_one(32'h40208233, 32'h0, 32'd5, 32'd9);   // sub x4,x1,x2
    checks++; if (bus.aluCtrl !== 6'd1 || bus.rd !== 5'd4) begin errors++; $display("FAIL sub_ctrl got=%0d,%0d exp=1,4", bus.aluCtrl, bus.rd); end
    drain();
    load_one(32'hFFF08013, 32'h0, 32'd7, 32'd0);   // addi x0,x1,-1
    checks++; if (bus.srcb !== 32'hFFFFFFFF || bus.reg_write !== 1'b0) begin errors++; $display("FAIL addi_x0 got=%h,%b exp=ffffffff,0", bus.srcb, bus.reg_write); end
    drain();
  endtask

  task automatic test_shift_imm();
    load_one(32'h40435293, 32'h0, 32'h80000000, 32'd0); // srai x5,x6,4
    checks++; if (bus.aluCtrl !== 6'd6 || bus.srcb !== 32'd4) begin errors++; $display("FAIL srai got=%0d,%h exp=6,4", bus.aluCtrl, bus.srcb); end
    checks++; if (bus.srca !== 32'h80000000 || bus.illegal !== 1'b0) begin errors++; $display("FAIL srai_a got=%h,%b exp=80000000,0", bus.srca, bus.illegal); end
    drain();
    load_one(32'h42435293, 32'h0, 32'h80000000, 32'd0); // funct7 0100001
    checks++; if (bus.illegal !== 1'b1 || bus.aluCtrl !== 6'd0) begin errors++; $display("FAIL srai_bad got=%b,%0d exp=1,0", bus.illegal, bus.aluCtrl); end
    checks++; if (bus.srca !== 32'd0 || bus.srcb !== 32'd0 || bus.reg_write !== 1'b0) begin errors++; $display("FAIL srai_bad_src got=%h,%h,%b exp=0,0,0", bus.srca, bus.srcb, bus.reg_write); end
    drain();
    checks++; if (bus.issue_cnt !== exp_cnt) begin errors++; $display("FAIL illegal_cnt got=%0d exp=%0d", bus.issue_cnt, exp_cnt); end
  endtask

  task automatic test_branch();
    load_one(32'h0020F063, 32'h0, 32'd3, 32'd8);   // bgeu x1,x2
    checks++; if (bus.aluCtrl !== 6'd15 || bus.is_branch !== 1'b1) begin errors++; $display("FAIL bgeu got=%0d,%b exp=15,1", bus.aluCtrl, bus.is_branch); end
    checks++; if (bus.reg_write !== 1'b0 || bus.srcb !== 32'd8) begin errors++; $display("FAIL bgeu_wb got=%b,%0d exp=0,8", bus.reg_write, bus.srcb); end
    drain();
    load_one(32'h0020A063, 32'h0, 32'd3, 32'd8);   // funct3 010
    checks++; if (bus.illegal !== 1'b1 || bus.is_branch !== 1'b0) begin errors++; $display("FAIL br010 got=%b,%b exp=1,0", bus.illegal, bus.is_branch); end
    drain();
  endtask

  task automatic test_store_upper();
    load_one(32'hFE20AE23, 32'h0, 32'h100, 32'd0); // sw x2,-4(x1)
    checks++; if (bus.srcb !== 32'hFFFFFFFC || bus.reg_write !== 1'b0) begin errors++; $display("FAIL sw got=%h,%b exp=fffffffc,0", bus.srcb, bus.reg_write); end
    drain();
    load_one(32'h12345397, 32'h1000, 32'hDEAD, 32'd0); // auipc x7,0x12345
    checks++; if (bus.srca !== 32'h1000 || bus.srcb !== 32'h12345000) begin errors++; $display("FAIL auipc got=%h,%h exp=1000,12345000", bus.srca, bus.srcb); end
    checks++; if (bus.aluCtrl !== 6'd0 || bus.reg_write !== 1'b1) begin errors++; $display("FAIL auipc_ctl got=%0d,%b exp=0,1", bus.aluCtrl, bus.reg_write); end
    drain();
    load_one(32'h008000EF, 32'h2000, 32'd0, 32'd0);  // jal x1,8
    checks++; if (bus.srca !== 32'h2000 || bus.srcb !== 32'd4) begin errors++; $display("FAIL jal got=%h,%h exp=2000,4", bus.srca, bus.srcb); end
    drain();
  endtask

  task automatic test_back_to_back();
    load_one(32'h002081B3, 32'h0, 32'd21, 32'd10); // A: add
    bus.in_valid = 1'b1; bus.instr = 32'h40208233; bus.rs1_data = 32'd50; bus.rs2_data = 32'd7;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d got=%b exp=0", k, bus.in_ready); end
      checks++; if (bus.srca !== 32'd21 || bus.aluCtrl !== 6'd0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold c%0d got=%0d,%0d,%b exp=21,0,1", k, bus.srca, bus.aluCtrl, bus.out_valid); end
    end
    checks++; if (bus.issue_cnt !== exp_cnt) begin errors++; $display("FAIL bp_cnt_hold got=%0d exp=%0d", bus.issue_cnt, exp_cnt); end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", bus.in_ready); end
    step();
    exp_cnt = exp_cnt + 32'd1;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.aluCtrl !== 6'd1 || bus.srca !== 32'd50) begin errors++; $display("FAIL b2b_load got=%b,%0d,%0d exp=1,1,50", bus.out_valid, bus.aluCtrl, bus.srca); end
    checks++; if (bus.issue_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_cnt got=%0d exp=%0d", bus.issue_cnt, exp_cnt); end
    drain();
  endtask

  task automatic test_flush();
    bus.in_valid = 1'b1; bus.instr = 32'h002081B3; bus.flush = 1'b1; bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b0 || bus.issue_cnt !== exp_cnt) begin errors++; $display("FAIL flush_load got=%b,%0d exp=0,%0d", bus.out_valid, bus.issue_cnt, exp_cnt); end
    bus.flush = 1'b0;
    load_one(32'h002081B3, 32'h0, 32'd1, 32'd2);
    bus.in_valid = 1'b1; bus.flush = 1'b1; bus.out_ready = 1'b1;
    step();
    exp_cnt = exp_cnt + 32'd1;
    checks++; if (bus.out_valid !== 1'b0 || bus.issue_cnt !== exp_cnt) begin errors++; $display("FAIL flush_xfer got=%b,%0d exp=0,%0d", bus.out_valid, bus.issue_cnt, exp_cnt); end
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    load_one(32'h002081B3, 32'h0, 32'd21, 32'd10);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.aluCtrl !== 6'd0) begin errors++; $display("FAIL arst_ctl got=%b,%0d exp=0,0", bus.out_valid, bus.aluCtrl); end
    checks++; if (bus.srca !== 32'd0 || bus.srcb !== 32'd0 || bus.issue_cnt !== 32'd0) begin errors++; $display("FAIL arst_data got=%0d,%0d,%0d exp=0,0,0", bus.srca, bus.srcb, bus.issue_cnt); end
    #3 rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_shift_imm();
    test_branch();
    test_store_upper();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
